// File: rtl/i2c_slave_responder_pkg.sv
// Shared I2C target definitions: FSM encoding, ACK/NACK levels, default address
// and small helpers used by the responder and its bus front end.
package i2c_slave_responder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_ADDR_ACK  = 3'd2,
        ST_RX_BYTE   = 3'd3,
        ST_RX_ACK    = 3'd4,
        ST_TX_BYTE   = 3'd5,
        ST_TX_ACK    = 3'd6,
        ST_WAIT_STOP = 3'd7
    } i2c_state_e;

    localparam logic       I2C_ACK            = 1'b0;
    localparam logic       I2C_NACK           = 1'b1;
    localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'h50;
    localparam logic [3:0] BITS_PER_BYTE      = 4'd8;

    function automatic logic [7:0] shift_in(input logic [7:0] cur, input logic b);
        return {cur[6:0], b};
    endfunction

    // Saturating bit counter step: stops at a full byte so it can never wrap.
    function automatic logic [3:0] cnt_step(input logic [3:0] cnt);
        return (cnt < BITS_PER_BYTE) ? (cnt + 4'd1) : cnt;
    endfunction

endpackage

// File: rtl/i2c_slave_responder_if.sv
// Pin and byte-strobe bundle between the I2C target responder and its environment.
interface i2c_slave_responder_if;
    logic       SCL_IN;
    logic       SDA_IN;
    logic       SDA_OE;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_req;
    logic       rw_dir;
    logic       addressed;
    logic       bus_busy;

    modport slave (
        input  SCL_IN, SDA_IN, tx_data,
        output SDA_OE, rx_data, rx_valid, tx_req, rw_dir, addressed, bus_busy
    );

    modport master (
        output SCL_IN, SDA_IN, tx_data,
        input  SDA_OE, rx_data, rx_valid, tx_req, rw_dir, addressed, bus_busy
    );
endinterface

// File: rtl/i2c_slave_responder_bus_sync.sv
// SCL/SDA synchroniser followed by a one-flop edge detector producing 1-cycle
// SCL edge strobes and START/STOP conditions.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_s_o,
    output logic sda_s_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_det_o,
    output logic stop_det_o
);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_prev_q;
    logic                   sda_prev_q;
    logic                   scl_s;
    logic                   sda_s;

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

    // Synchroniser chains plus previous-value flops; idle bus level is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= {SYNC_STAGES{1'b1}};
            sda_sync_q <= {SYNC_STAGES{1'b1}};
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    assign scl_s_o     = scl_s;
    assign sda_s_o     = sda_s;
    assign scl_rise_o  = scl_s & ~scl_prev_q;
    assign scl_fall_o  = ~scl_s & scl_prev_q;
    // SCL must be high on both sides of the SDA edge to qualify as START/STOP.
    assign start_det_o = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det_o  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_slave_responder.sv
// I2C target responder: address match, byte receive/transmit with ACK handling,
// byte-level pulse interface to local logic. No clock stretching.
module i2c_slave_responder
    import i2c_slave_responder_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = DEFAULT_SLAVE_ADDR,
    parameter int         SYNC_STAGES = 2
) (
    input logic                  PCLK,
    input logic                  PRESETN,
    i2c_slave_responder_if.slave bus
);

    logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det, bit_rise_s;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk         (PCLK),
        .rst_n       (PRESETN),
        .scl_i       (bus.SCL_IN),
        .sda_i       (bus.SDA_IN),
        .scl_s_o     (scl_s),
        .sda_s_o     (sda_s),
        .scl_rise_o  (scl_rise),
        .scl_fall_o  (scl_fall),
        .start_det_o (start_det),
        .stop_det_o  (stop_det)
    );

    assign bit_rise_s = scl_rise & scl_s;

    i2c_state_e state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       sda_oe_q, sda_oe_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_req_q, tx_req_d;
    logic       rw_dir_q, rw_dir_d;
    logic       addressed_q, addressed_d;
    logic       bus_busy_q, bus_busy_d;
    logic       addr_hit_q, addr_hit_d;
    logic       nack_q, nack_d;

    // State and output registers; async reset releases SDA immediately.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 8'h00;
            rx_data_q   <= 8'h00;
            sda_oe_q    <= 1'b0;
            rx_valid_q  <= 1'b0;
            tx_req_q    <= 1'b0;
            rw_dir_q    <= 1'b0;
            addressed_q <= 1'b0;
            bus_busy_q  <= 1'b0;
            addr_hit_q  <= 1'b0;
            nack_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            sda_oe_q    <= sda_oe_d;
            rx_valid_q  <= rx_valid_d;
            tx_req_q    <= tx_req_d;
            rw_dir_q    <= rw_dir_d;
            addressed_q <= addressed_d;
            bus_busy_q  <= bus_busy_d;
            addr_hit_q  <= addr_hit_d;
            nack_q      <= nack_d;
        end
    end

    // Next-state logic; bus conditions override whatever the FSM is doing.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        sda_oe_d    = sda_oe_q;
        rx_valid_d  = 1'b0;
        tx_req_d    = 1'b0;
        rw_dir_d    = rw_dir_q;
        addressed_d = addressed_q;
        bus_busy_d  = bus_busy_q;
        addr_hit_d  = addr_hit_q;
        nack_d      = nack_q;

        if (stop_det) begin
            state_d     = ST_IDLE;
            bit_cnt_d   = 4'd0;
            sda_oe_d    = 1'b0;
            addressed_d = 1'b0;
            bus_busy_d  = 1'b0;
        end else if (start_det) begin
            state_d     = ST_ADDR;
            bit_cnt_d   = 4'd0;
            sda_oe_d    = 1'b0;
            addressed_d = 1'b0;
            bus_busy_d  = 1'b1;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (bit_rise_s && (bit_cnt_q < BITS_PER_BYTE)) begin
                        shift_d   = shift_in(shift_q, sda_s);
                        bit_cnt_d = cnt_step(bit_cnt_q);
                        if (bit_cnt_q == 4'd7) begin
                            addr_hit_d = (shift_q[6:0] == SLAVE_ADDR);
                        end else begin
                            addr_hit_d = addr_hit_q;
                        end
                    end else if (scl_fall && (bit_cnt_q == BITS_PER_BYTE)) begin
                        bit_cnt_d = 4'd0;
                        if (addr_hit_q) begin
                            state_d     = ST_ADDR_ACK;
                            sda_oe_d    = 1'b1;
                            rw_dir_d    = shift_q[0];
                            addressed_d = 1'b1;
                        end else begin
                            state_d = ST_WAIT_STOP;
                        end
                    end else begin
                        state_d = ST_ADDR;
                    end
                end
                ST_ADDR_ACK: begin
                    if (bit_rise_s) begin
                        tx_req_d = rw_dir_q;
                    end else if (scl_fall && rw_dir_q) begin
                        shift_d   = bus.tx_data;
                        sda_oe_d  = ~bus.tx_data[7];
                        bit_cnt_d = 4'd1;
                        state_d   = ST_TX_BYTE;
                    end else if (scl_fall) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 4'd0;
                        state_d   = ST_RX_BYTE;
                    end else begin
                        state_d = ST_ADDR_ACK;
                    end
                end
                ST_RX_BYTE: begin
                    if (bit_rise_s && (bit_cnt_q < BITS_PER_BYTE)) begin
                        shift_d   = shift_in(shift_q, sda_s);
                        bit_cnt_d = cnt_step(bit_cnt_q);
                        if (bit_cnt_q == 4'd7) begin
                            rx_data_d  = shift_in(shift_q, sda_s);
                            rx_valid_d = 1'b1;
                        end else begin
                            rx_valid_d = 1'b0;
                        end
                    end else if (scl_fall && (bit_cnt_q == BITS_PER_BYTE)) begin
                        sda_oe_d  = 1'b1;
                        bit_cnt_d = 4'd0;
                        state_d   = ST_RX_ACK;
                    end else begin
                        state_d = ST_RX_BYTE;
                    end
                end
                ST_RX_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 4'd0;
                        state_d   = ST_RX_BYTE;
                    end else begin
                        state_d = ST_RX_ACK;
                    end
                end
                ST_TX_BYTE: begin
                    // bit_cnt holds how many bits are already on the wire; shift_q[7] is current.
                    if (scl_fall && (bit_cnt_q == BITS_PER_BYTE)) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 4'd0;
                        state_d   = ST_TX_ACK;
                    end else if (scl_fall) begin
                        sda_oe_d  = ~shift_q[6];
                        shift_d   = shift_in(shift_q, 1'b0);
                        bit_cnt_d = cnt_step(bit_cnt_q);
                    end else begin
                        state_d = ST_TX_BYTE;
                    end
                end
                ST_TX_ACK: begin
                    if (bit_rise_s) begin
                        nack_d   = sda_s;
                        tx_req_d = (sda_s == I2C_ACK);
                    end else if (scl_fall && (nack_q == I2C_ACK)) begin
                        shift_d   = bus.tx_data;
                        sda_oe_d  = ~bus.tx_data[7];
                        bit_cnt_d = 4'd1;
                        state_d   = ST_TX_BYTE;
                    end else if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        state_d  = ST_WAIT_STOP;
                    end else begin
                        state_d = ST_TX_ACK;
                    end
                end
                ST_WAIT_STOP: begin
                    sda_oe_d = 1'b0;
                end
                default: begin
                    sda_oe_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            endcase
        end
    end

    assign bus.SDA_OE    = sda_oe_q;
    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.tx_req    = tx_req_q;
    assign bus.rw_dir    = rw_dir_q;
    assign bus.addressed = addressed_q;
    assign bus.bus_busy  = bus_busy_q;

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Directed bench: an I2C master model drives SCL/SDA (wired-AND with SDA_OE)
// through write, read, wrong-address, repeated-START, early-STOP and reset cases.
`timescale 1ns/1ps
module tb_i2c_slave_responder;
    import i2c_slave_responder_pkg::*;

    localparam int Q = 8;

    logic       PCLK;
    logic       PRESETN;
    logic       scl_m;
    logic       sda_m;
    logic [7:0] tx_byte;
    int         n_cmp;
    int         n_err;
    int         rx_cnt;
    int         tx_cnt;
    int         both_cnt;
    logic [7:0] rx_last;
    logic [7:0] rx_prev;

    i2c_slave_responder_if bus ();

    assign bus.SCL_IN  = scl_m;
    assign bus.SDA_IN  = sda_m & ~bus.SDA_OE;
    assign bus.tx_data = tx_byte;

    i2c_slave_responder #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
        .PCLK    (PCLK),
        .PRESETN (PRESETN),
        .bus     (bus.slave)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // Pulse monitor: counts strobes and keeps the last two received bytes.
    always @(posedge PCLK) begin
        if (bus.rx_valid === 1'b1) begin
            rx_cnt  = rx_cnt + 1;
            rx_prev = rx_last;
            rx_last = bus.rx_data;
        end
        if (bus.tx_req === 1'b1) tx_cnt = tx_cnt + 1;
        if ((bus.rx_valid === 1'b1) && (bus.tx_req === 1'b1)) both_cnt = both_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge PCLK);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; scl_m = 1'b1; wait_clks(Q);
        sda_m = 1'b0; wait_clks(Q);
        scl_m = 1'b0; wait_clks(Q);
    endtask

    task automatic i2c_rep_start();
        sda_m = 1'b1; wait_clks(Q);
        scl_m = 1'b1; wait_clks(Q);
        sda_m = 1'b0; wait_clks(Q);
        scl_m = 1'b0; wait_clks(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_clks(Q);
        scl_m = 1'b1; wait_clks(Q);
        sda_m = 1'b1; wait_clks(Q);
    endtask

    task automatic clock_bit(input logic b, output logic seen);
        sda_m = b; wait_clks(Q);
        scl_m = 1'b1; wait_clks(Q / 2);
        seen = bus.SDA_IN;
        wait_clks(Q / 2);
        scl_m = 1'b0; wait_clks(Q);
    endtask

    task automatic write_byte(input logic [7:0] data, output logic ack);
        logic dummy;
        for (int i = 7; i >= 0; i--) clock_bit(data[i], dummy);
        clock_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic master_ack, input logic [7:0] next_tx, output logic [7:0] data);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, b);
            data[i] = b;
        end
        tx_byte = next_tx;
        clock_bit(master_ack, b);
    endtask

    initial begin
        logic       ack;
        logic [7:0] d;
        int         rx_base;
        int         tx_base;

        n_cmp = 0; n_err = 0; rx_cnt = 0; tx_cnt = 0; both_cnt = 0;
        rx_last = 8'h00; rx_prev = 8'h00;
        PRESETN = 1'b0; scl_m = 1'b1; sda_m = 1'b1; tx_byte = 8'h00;
        wait_clks(5);
        check_eq("rst_sda_oe", bus.SDA_OE, 1'b0);
        check_eq("rst_rx_data", bus.rx_data, 8'h00);
        check_eq("rst_rx_valid", bus.rx_valid, 1'b0);
        check_eq("rst_tx_req", bus.tx_req, 1'b0);
        check_eq("rst_rw_dir", bus.rw_dir, 1'b0);
        check_eq("rst_addressed", bus.addressed, 1'b0);
        check_eq("rst_bus_busy", bus.bus_busy, 1'b0);
        check_eq("rst_state", dut.state_q, ST_IDLE);
        check_eq("rst_bit_cnt", dut.bit_cnt_q, 4'd0);
        PRESETN = 1'b1;
        wait_clks(5);

        // Write 0xA0, 0x3C, 0xC3, STOP.
        rx_base = rx_cnt;
        i2c_start();
        check_eq("wr_busy", bus.bus_busy, 1'b1);
        check_eq("wr_state_addr", dut.state_q, ST_ADDR);
        write_byte(8'hA0, ack);
        check_eq("wr_addr_ack", ack, I2C_ACK);
        check_eq("wr_addressed", bus.addressed, 1'b1);
        check_eq("wr_rw_dir", bus.rw_dir, 1'b0);
        write_byte(8'h3C, ack);
        check_eq("wr_d0_ack", ack, I2C_ACK);
        write_byte(8'hC3, ack);
        check_eq("wr_d1_ack", ack, I2C_ACK);
        i2c_stop();
        check_eq("wr_rx_count", rx_cnt - rx_base, 2);
        check_eq("wr_rx_first", rx_prev, 8'h3C);
        check_eq("wr_rx_second", rx_last, 8'hC3);
        check_eq("wr_rx_data", bus.rx_data, 8'hC3);
        check_eq("wr_busy_end", bus.bus_busy, 1'b0);
        check_eq("wr_addressed_end", bus.addressed, 1'b0);
        check_eq("wr_state_idle", dut.state_q, ST_IDLE);

        // Read 0xA1: 0x5A (master ACK), 0x81 (master NACK).
        tx_byte = 8'h5A;
        tx_base = tx_cnt;
        i2c_start();
        write_byte(8'hA1, ack);
        check_eq("rd_addr_ack", ack, I2C_ACK);
        check_eq("rd_rw_dir", bus.rw_dir, 1'b1);
        check_eq("rd_tx_req_1", tx_cnt - tx_base, 1);
        read_byte(I2C_ACK, 8'h81, d);
        check_eq("rd_byte0", d, 8'h5A);
        read_byte(I2C_NACK, 8'h00, d);
        check_eq("rd_byte1", d, 8'h81);
        check_eq("rd_tx_req_2", tx_cnt - tx_base, 2);
        check_eq("rd_state_wait", dut.state_q, ST_WAIT_STOP);
        check_eq("rd_sda_rel", bus.SDA_OE, 1'b0);
        i2c_stop();
        check_eq("rd_busy_end", bus.bus_busy, 1'b0);

        // Wrong address 0x51.
        rx_base = rx_cnt;
        i2c_start();
        write_byte(8'hA2, ack);
        check_eq("na_nack", ack, I2C_NACK);
        check_eq("na_addressed", bus.addressed, 1'b0);
        check_eq("na_state_wait", dut.state_q, ST_WAIT_STOP);
        write_byte(8'h55, ack);
        check_eq("na_data_nack", ack, I2C_NACK);
        check_eq("na_still_wait", dut.state_q, ST_WAIT_STOP);
        i2c_stop();
        check_eq("na_rx_count", rx_cnt - rx_base, 0);
        check_eq("na_state_idle", dut.state_q, ST_IDLE);

        // Write 0x11, repeated START, read.
        rx_base = rx_cnt;
        tx_base = tx_cnt;
        tx_byte = 8'hE7;
        i2c_start();
        write_byte(8'hA0, ack);
        check_eq("rs_addr_ack", ack, I2C_ACK);
        write_byte(8'h11, ack);
        check_eq("rs_d_ack", ack, I2C_ACK);
        i2c_rep_start();
        check_eq("rs_busy", bus.bus_busy, 1'b1);
        check_eq("rs_addressed_clr", bus.addressed, 1'b0);
        check_eq("rs_state_addr", dut.state_q, ST_ADDR);
        write_byte(8'hA1, ack);
        check_eq("rs_rd_ack", ack, I2C_ACK);
        check_eq("rs_rw_dir", bus.rw_dir, 1'b1);
        check_eq("rs_rx_count", rx_cnt - rx_base, 1);
        check_eq("rs_rx_data", rx_last, 8'h11);
        check_eq("rs_tx_req", tx_cnt - tx_base, 1);
        read_byte(I2C_NACK, 8'h00, d);
        check_eq("rs_rd_byte", d, 8'hE7);
        i2c_stop();

        // STOP after 4 data bits.
        rx_base = rx_cnt;
        i2c_start();
        write_byte(8'hA0, ack);
        check_eq("es_addr_ack", ack, I2C_ACK);
        clock_bit(1'b1, ack);
        clock_bit(1'b0, ack);
        clock_bit(1'b1, ack);
        clock_bit(1'b1, ack);
        i2c_stop();
        check_eq("es_rx_count", rx_cnt - rx_base, 0);
        check_eq("es_state_idle", dut.state_q, ST_IDLE);
        check_eq("es_sda_oe", bus.SDA_OE, 1'b0);
        check_eq("es_busy", bus.bus_busy, 1'b0);
        i2c_start();
        write_byte(8'hA0, ack);
        check_eq("es_re_ack", ack, I2C_ACK);
        check_eq("es_re_addressed", bus.addressed, 1'b1);
        i2c_stop();

        // Async reset while driving a 0 data bit.
        tx_byte = 8'h00;
        i2c_start();
        write_byte(8'hA1, ack);
        check_eq("ar_addr_ack", ack, I2C_ACK);
        check_eq("ar_state_tx", dut.state_q, ST_TX_BYTE);
        check_eq("ar_driving", bus.SDA_OE, 1'b1);
        #3 PRESETN = 1'b0;
        #1 check_eq("ar_sda_rel", bus.SDA_OE, 1'b0);
        wait_clks(2);
        check_eq("ar_rx_data", bus.rx_data, 8'h00);
        check_eq("ar_rw_dir", bus.rw_dir, 1'b0);
        check_eq("ar_addressed", bus.addressed, 1'b0);
        check_eq("ar_busy", bus.bus_busy, 1'b0);
        check_eq("ar_tx_req", bus.tx_req, 1'b0);
        check_eq("ar_state", dut.state_q, ST_IDLE);
        PRESETN = 1'b1;
        wait_clks(Q);
        i2c_stop();
        i2c_start();
        write_byte(8'hA0, ack);
        check_eq("ar_re_ack", ack, I2C_ACK);
        check_eq("ar_re_addressed", bus.addressed, 1'b1);
        i2c_stop();

        check_eq("no_rx_tx_overlap", both_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
